fp32_normalizer_pipe: RTL

Post-addition normaliser for the FP32 adder datapath. It is the left-shift counterpart to the alignment right shifter.
- Takes the raw significand sum (with carry-out), the pre-normalisation exponent and the sign.
- Handles carry-out by a 1-bit right shift, leading-zero count plus left barrel shift, exponent adjustment, and denormal, zero and overflow cases.
- Two-stage pipeline with valid/ready handshake on both sides; sits between the significand adder and the rounding/pack stage.

---
 rtl/fp32_normalizer_pipe.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp32_normalizer_pipe.sv
// Post-addition normaliser for the FP32 adder: carry right-shift, leading-zero
// left shift, exponent adjust and zero/denormal/overflow handling in two stages.
module fp32_normalizer_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W:0]   in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_zero,
    output logic              out_ovf
);

    localparam int LZC_W = $clog2(MANT_W + 1);
    localparam int XW    = EXP_W + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    // Leading zeros of the significand field; MANT_W when it is all zero.
    function automatic logic [LZC_W-1:0] count_lz(input logic [MANT_W-1:0] m);
        logic [LZC_W-1:0] n;
        n = LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (m[i]) begin
                n = LZC_W'(MANT_W - 1 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Zero-filling logarithmic left shifter, largest stage first.
    function automatic logic [MANT_W-1:0] shift_left(input logic [MANT_W-1:0] m,
                                                     input logic [LZC_W-1:0] amt);
        logic [MANT_W-1:0] r;
        r = m;
        for (int lvl = LZC_W - 1; lvl >= 0; lvl--) begin
            if (amt[lvl]) begin
                r = r << (1 << lvl);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic              s1_adv_s;
    logic              s2_adv_s;

    logic              s1_valid_q, s1_valid_d;
    logic [MANT_W:0]   s1_mant_q,  s1_mant_d;
    logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
    logic              s1_sign_q,  s1_sign_d;
    logic              s1_carry_q, s1_carry_d;
    logic [LZC_W-1:0]  s1_lzc_q,   s1_lzc_d;
    logic              s1_zero_q,  s1_zero_d;

    logic              out_valid_q, out_valid_d;
    logic [MANT_W-1:0] out_mant_q,  out_mant_d;
    logic [EXP_W-1:0]  out_exp_q,   out_exp_d;
    logic              out_sign_q,  out_sign_d;
    logic              out_zero_q,  out_zero_d;
    logic              out_ovf_q,   out_ovf_d;

    logic [XW-1:0]     e_s;
    logic [XW-1:0]     e_inc_s;
    logic [XW-1:0]     lzc_x_s;
    logic [LZC_W-1:0]  shamt_s;
    logic [MANT_W-1:0] shifted_s;
    logic [MANT_W-1:0] norm_mant_s;
    logic [EXP_W-1:0]  norm_exp_s;
    logic              norm_zero_s;
    logic              norm_ovf_s;

    // Handshake: a stage may advance when it is empty or its successor advances.
    always_comb begin
        s2_adv_s = ~out_valid_q | out_ready;
        s1_adv_s = ~s1_valid_q | s2_adv_s;
        in_ready = s1_adv_s & rst_n;
    end

    // Stage 1 next state: capture the word plus carry, lzc and zero flags.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_exp_d   = s1_exp_q;
        s1_sign_d  = s1_sign_q;
        s1_carry_d = s1_carry_q;
        s1_lzc_d   = s1_lzc_q;
        s1_zero_d  = s1_zero_q;
        if (s1_adv_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mant_d  = in_mant;
                s1_exp_d   = in_exp;
                s1_sign_d  = in_sign;
                s1_carry_d = in_mant[MANT_W];
                s1_lzc_d   = count_lz(in_mant[MANT_W-1:0]);
                s1_zero_d  = (in_mant == {(MANT_W + 1){1'b0}});
            end else begin
                s1_mant_d = s1_mant_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_carry_q <= 1'b0;
            s1_lzc_q   <= '0;
            s1_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mant_q  <= s1_mant_d;
            s1_exp_q   <= s1_exp_d;
            s1_sign_q  <= s1_sign_d;
            s1_carry_q <= s1_carry_d;
            s1_lzc_q   <= s1_lzc_d;
            s1_zero_q  <= s1_zero_d;
        end
    end

    // Normalisation: exponent math at EXP_W+1 bits, one shared shifter.
    always_comb begin
        e_s         = {1'b0, s1_exp_q};
        e_inc_s     = e_s + XW'(1);
        lzc_x_s     = XW'(s1_lzc_q);
        shamt_s     = '0;
        norm_mant_s = '0;
        norm_exp_s  = '0;
        norm_zero_s = 1'b0;
        norm_ovf_s  = 1'b0;
        if (s1_zero_q) begin
            norm_zero_s = 1'b1;
        end else if (s1_carry_q) begin
            if (e_inc_s == {1'b0, EXP_MAX}) begin
                norm_exp_s = EXP_MAX;
                norm_ovf_s = 1'b1;
            end else begin
                norm_mant_s = s1_mant_q[MANT_W:1];
                norm_exp_s  = EXP_W'(e_inc_s);
            end
        end else if (lzc_x_s < e_s) begin
            shamt_s     = s1_lzc_q;
            norm_mant_s = shifted_s;
            norm_exp_s  = EXP_W'(e_s - lzc_x_s);
        end else begin
            // Result stays denormal: shift only as far as exponent 1 allows.
            if (e_s == {XW{1'b0}}) begin
                shamt_s = '0;
            end else begin
                shamt_s = LZC_W'(e_s - XW'(1));
            end
            norm_mant_s = shifted_s;
            norm_exp_s  = '0;
        end
    end

    assign shifted_s = shift_left(s1_mant_q[MANT_W-1:0], shamt_s);

    // Stage 2 next state: load on s1->s2 transfer, hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_sign_d  = out_sign_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_mant_d = norm_mant_s;
                out_exp_d  = norm_exp_s;
                out_sign_d = s1_sign_q;
                out_zero_d = norm_zero_s;
                out_ovf_d  = norm_ovf_s;
            end else begin
                out_mant_d = out_mant_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Stage 2 (output) registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_sign_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_sign_q  <= out_sign_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mant  = out_mant_q;
    assign out_exp   = out_exp_q;
    assign out_sign  = out_sign_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;

endmodule
